imem_line_server: RTL and testbench

Instruction-memory responder for the instruction cache's line-fill port. It accepts a fill request (`mem_r`, `mem_addr`) and reads four consecutive 32-bit words from an internal word-wide synchronous RAM. It assembles them into one 128-bit line and returns it with a single-cycle `mem_ready` pulse. It sits between the I-cache and main instruction storage, and provides the bench and loader with a preload port.

---
 rtl/imem_line_server_pkg.sv | 15 +
 rtl/imem_line_server_if.sv | 11 +
 rtl/imem_word_ram.sv | 21 ++
 rtl/imem_line_server.sv | 85 ++++++++
 tb/tb_imem_line_server.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/imem_line_server_pkg.sv
// imem_line_server_pkg: shared FSM encoding and line geometry for the I-cache line server
package imem_line_server_pkg;
  localparam int LINE_WORDS = 4;
  localparam int WORD_W = 32;
  localparam int LINE_W = 128;
  localparam int OFFSET_W = 4;
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_FILL,
    S_READY,
    S_HOLD
  } state_e;
endpackage

// File: rtl/imem_line_server_if.sv
// imem_line_server_if: I-cache line-fill port between the cache (master) and the line server (slave)
interface imem_line_server_if;
  import imem_line_server_pkg::*;
  logic mem_r;
  logic [31:0] mem_addr;
  logic [LINE_W-1:0] mem_data;
  logic mem_ready;
  logic busy;
  modport master(output mem_r, mem_addr, input mem_data, mem_ready, busy);
  modport slave(input mem_r, mem_addr, output mem_data, mem_ready, busy);
endinterface

// File: rtl/imem_word_ram.sv
// imem_word_ram: word-wide RAM, one write port and one 1-cycle synchronous read port returning old data on collision
module imem_word_ram
  import imem_line_server_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data
);
  logic [WORD_W-1:0] mem [2**ADDR_W];
  logic [WORD_W-1:0] rd_data_q;
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data_q <= mem[rd_addr];
  end
  assign rd_data = rd_data_q;
endmodule

// File: rtl/imem_line_server.sv
// imem_line_server: reads four consecutive RAM words per fill request and returns them as one 128-bit line
module imem_line_server
  import imem_line_server_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                clk,
  input  logic                rst,
  imem_line_server_if.slave   bus,
  input  logic                load_we,
  input  logic [ADDR_W-1:0]   load_addr,
  input  logic [WORD_W-1:0]   load_data
);
  state_e state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic [1:0] k_q, k_d;
  logic [ADDR_W-3:0] line_q, line_d;
  logic cap_v_q, cap_v_d;
  logic [1:0] cap_k_q, cap_k_d;
  logic [LINE_W-1:0] line_buf_q, line_buf_d;
  logic [WORD_W-1:0] rd_data;
  logic addr_unused;
  assign addr_unused = ^{bus.mem_addr[31:ADDR_W+2], bus.mem_addr[OFFSET_W-1:0]};
  imem_word_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk(clk),
    .rd_addr({line_q, k_q}),
    .rd_data(rd_data),
    .we(load_we),
    .wr_addr(load_addr),
    .wr_data(load_data)
  );
  always_comb begin
    state_d = state_q;
    wait_d = wait_q;
    k_d = k_q;
    line_d = line_q;
    line_buf_d = line_buf_q;
    // RAM data lags its address by one cycle, so the capture slot trails the READ slot
    cap_v_d = state_q == S_READ;
    cap_k_d = k_q;
    if (cap_v_q) line_buf_d[WORD_W*cap_k_q +: WORD_W] = rd_data;
    case (state_q)
      S_IDLE: if (bus.mem_r) begin
        line_d = bus.mem_addr[ADDR_W+1:OFFSET_W];
        wait_d = 4'(WAIT_CYCLES);
        k_d = '0;
        state_d = WAIT_CYCLES > 0 ? S_WAIT : S_READ;
      end
      S_WAIT: begin
        wait_d = wait_q - 4'd1;
        state_d = wait_q == 4'd1 ? S_READ : S_WAIT;
      end
      S_READ: begin
        k_d = k_q + 2'd1;
        state_d = k_q == 2'd3 ? S_FILL : S_READ;
      end
      S_FILL: state_d = S_READY;
      S_READY: state_d = S_HOLD;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wait_q <= '0;
      k_q <= '0;
      line_q <= '0;
      cap_v_q <= 1'b0;
      cap_k_q <= '0;
      line_buf_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
      k_q <= k_d;
      line_q <= line_d;
      cap_v_q <= cap_v_d;
      cap_k_q <= cap_k_d;
      line_buf_q <= line_buf_d;
    end
  end
  assign bus.mem_data = line_buf_q;
  assign bus.mem_ready = state_q == S_READY;
  assign bus.busy = state_q != S_IDLE;
endmodule

// File: tb/tb_imem_line_server.sv
// tb_imem_line_server: randomized self-checking bench against a word-array model of the line server
module tb_imem_line_server;
  logic clk = 1'b0;
  logic rst;
  logic load_we;
  logic [9:0] load_addr;
  logic [31:0] load_data;
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] model [1024];
  imem_line_server_if bus0();
  imem_line_server_if bus3();
  imem_line_server #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data)
  );
  imem_line_server #(.ADDR_W(10), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic set_req(input bit sel, input logic r, input logic [31:0] a);
    if (sel) begin bus3.mem_r = r; bus3.mem_addr = a; end
    else begin bus0.mem_r = r; bus0.mem_addr = a; end
  endtask
  task automatic preload(input int a, input logic [31:0] d);
    @(negedge clk);
    load_we = 1'b1;
    load_addr = 10'(a);
    load_data = d;
    model[a] = d;
    @(negedge clk);
    load_we = 1'b0;
  endtask
  task automatic wait_idle(input bit sel);
    bit ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if ((sel ? bus3.busy : bus0.busy) === 1'b0) ok = 1;
    end
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL wait_idle sel=%0d: busy never dropped", sel); end
  endtask
  // Accept happens in the cycle of the first negedge after idle (cycle T); loop index j is cycle T+j.
  task automatic do_fill(input bit sel, input logic [31:0] addr, input int w, input int wr_cyc,
                         input int wr_a, input logic [31:0] wr_d, input string nm);
    logic [127:0] exp_line, data;
    logic rdy, bsy;
    int base;
    base = int'((addr % 32'd4096) / 32'd16) * 4;
    for (int k = 0; k < 4; k++) exp_line[32*k +: 32] = model[base + k];
    wait_idle(sel);
    set_req(sel, 1'b1, addr);
    for (int j = 1; j <= 8 + w; j++) begin
      @(negedge clk);
      load_we = (j == wr_cyc);
      if (j == wr_cyc) begin load_addr = 10'(wr_a); load_data = wr_d; model[wr_a] = wr_d; end
      rdy = sel ? bus3.mem_ready : bus0.mem_ready;
      bsy = sel ? bus3.busy : bus0.busy;
      data = sel ? bus3.mem_data : bus0.mem_data;
      n_vec++;
      if (rdy !== 1'(j == 6 + w)) begin
        n_err++; $display("FAIL %s ready T+%0d: got %b want %b", nm, j, rdy, j == 6 + w);
      end
      n_vec++;
      if (bsy !== 1'(j < 8 + w)) begin
        n_err++; $display("FAIL %s busy T+%0d: got %b want %b", nm, j, bsy, j < 8 + w);
      end
      if (j >= 6 + w) begin
        n_vec++;
        if (data !== exp_line) begin
          n_err++; $display("FAIL %s data T+%0d: got %h want %h", nm, j, data, exp_line);
        end
      end
      if (j == 6 + w) set_req(sel, 1'b0, addr);
    end
    load_we = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    load_we = 1'b0;
    load_addr = '0;
    load_data = '0;
    set_req(0, 1'b0, '0);
    set_req(1, 1'b0, '0);
    #2 rst = 1'b0;
    #2;
    n_vec++;
    if (bus0.busy !== 1'b0 || bus3.busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b/%b want 0/0", bus0.busy, bus3.busy); end
    n_vec++;
    if (bus0.mem_ready !== 1'b0 || bus3.mem_ready !== 1'b0) begin n_err++; $display("FAIL reset ready: got %b/%b want 0/0", bus0.mem_ready, bus3.mem_ready); end
    n_vec++;
    if (bus0.mem_data !== 128'd0 || bus3.mem_data !== 128'd0) begin n_err++; $display("FAIL reset data: got %h/%h want 0", bus0.mem_data, bus3.mem_data); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask
  task automatic test_preload();
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      load_we = 1'b1;
      load_addr = 10'(i);
      load_data = $urandom;
      model[i] = load_data;
    end
    @(negedge clk);
    load_we = 1'b0;
    for (int i = 0; i < 8; i++) preload(i, 32'h1000_0000 + 32'(i));
  endtask
  task automatic test_basic();
    do_fill(0, 32'h0000_0010, 0, -1, 0, 0, "basic");
    n_vec++;
    if (bus0.mem_data !== 128'h10000007_10000006_10000005_10000004) begin
      n_err++; $display("FAIL basic const: got %h want 10000007100000061000000510000004", bus0.mem_data);
    end
    do_fill(0, 32'h0000_001C, 0, -1, 0, 0, "offset");
  endtask
  task automatic test_wait();
    do_fill(1, 32'h0000_0000, 3, -1, 0, 0, "wait3");
    n_vec++;
    if (bus3.mem_data !== 128'h10000003_10000002_10000001_10000000) begin
      n_err++; $display("FAIL wait3 const: got %h want 10000003100000021000000110000000", bus3.mem_data);
    end
  endtask
  task automatic test_back_to_back();
    logic [127:0] exp_line;
    for (int k = 0; k < 4; k++) exp_line[32*k +: 32] = model[4 + k];
    wait_idle(0);
    set_req(0, 1'b1, 32'h0000_0010);
    for (int j = 1; j <= 32; j++) begin
      @(negedge clk);
      n_vec++;
      if (bus0.mem_ready !== 1'(j % 8 == 6)) begin
        n_err++; $display("FAIL b2b ready T+%0d: got %b want %b", j, bus0.mem_ready, j % 8 == 6);
      end
      n_vec++;
      if (bus0.busy !== 1'(j % 8 != 0)) begin
        n_err++; $display("FAIL b2b busy T+%0d: got %b want %b", j, bus0.busy, j % 8 != 0);
      end
      if (j % 8 == 6) begin
        n_vec++;
        if (bus0.mem_data !== exp_line) begin n_err++; $display("FAIL b2b data T+%0d: got %h want %h", j, bus0.mem_data, exp_line); end
      end
      if (j == 30) set_req(0, 1'b0, 32'h0);
    end
  endtask
  task automatic test_reset_mid_fill();
    wait_idle(0);
    set_req(0, 1'b1, 32'h0000_0010);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    if (bus0.busy !== 1'b0) begin n_err++; $display("FAIL midrst busy: got %b want 0", bus0.busy); end
    n_vec++;
    if (bus0.mem_data !== 128'd0) begin n_err++; $display("FAIL midrst data: got %h want 0", bus0.mem_data); end
    @(negedge clk);
    rst = 1'b1;
    set_req(0, 1'b0, 32'h0);
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      n_vec++;
      if (bus0.mem_ready !== 1'b0 || bus0.busy !== 1'b0) begin
        n_err++; $display("FAIL midrst quiet %0d: ready %b busy %b want 0 0", j, bus0.mem_ready, bus0.busy);
      end
      n_vec++;
      if (bus0.mem_data !== 128'd0) begin n_err++; $display("FAIL midrst hold %0d: got %h want 0", j, bus0.mem_data); end
    end
    do_fill(0, 32'h0000_0010, 0, -1, 0, 0, "after_rst");
  endtask
  task automatic test_alias_collision();
    do_fill(0, 32'h0000_1010, 0, 2, 5, 32'hDEAD_BEEF, "alias_coll");
    n_vec++;
    if (bus0.mem_data[63:32] !== 32'h1000_0005) begin
      n_err++; $display("FAIL collision word1: got %h want 10000005", bus0.mem_data[63:32]);
    end
    do_fill(0, 32'h0000_0010, 0, -1, 0, 0, "post_write");
    n_vec++;
    if (bus0.mem_data[63:32] !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL post_write word1: got %h want deadbeef", bus0.mem_data[63:32]);
    end
  endtask
  task automatic test_random();
    bit sel;
    for (int i = 0; i < 24; i++) begin
      sel = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) preload(int'($urandom_range(0, 1023)), $urandom);
      do_fill(sel, $urandom, sel ? 3 : 0, -1, 0, 0, "random");
    end
  endtask
  initial begin
    test_reset();
    test_preload();
    test_basic();
    test_wait();
    test_back_to_back();
    test_reset_mid_fill();
    test_alias_collision();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
